rf_wr_arbiter: RTL and testbench
================================

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: cycles a buffered ext write may wait before the pipeline is stalled.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock.
REQ-003 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have pipe_wr_en  input  1  WB-stage write request (cannot be back-pressured).
REQ-005 SHALL have pipe_wr_addr  input  5  WB destination register.
REQ-006 SHALL have pipe_wr_data  input  32  WB write data.
REQ-007 SHALL have ext_req_valid  input  1  long-latency unit (div/load-return) write request.
REQ-008 SHALL have ext_req_ready  output  1  ext request accepted when valid&ready.
REQ-009 SHALL have ext_req_addr / ext_req_data  input  5 / 32  ext destination and data.
REQ-010 SHALL have pipe_stall  output  1  pipeline must present pipe_wr_en=0 in the next cycle.
REQ-011 SHALL have wr_en / wr_addr / wr_data  output  1 / 5 / 32  registered regfile write port.

Function
REQ-012 SHALL register the write port: the winner in cycle N appears on wr_* in cycle N+1, 1-cycle latency.
REQ-013 SHALL hold one ext entry in a single-entry buffer; ext_req_ready = buffer empty (registered, no same-cycle refill after drain).
REQ-014 SHALL treat any write with addr 0 as a no-op: never drives wr_en, never occupies the port, ext addr-0 accepted and discarded.
REQ-015 SHALL grant the port to the pipeline whenever pipe_wr_en=1 and pipe_wr_addr!=0 (pipeline priority).
REQ-016 SHALL drain the buffered ext entry in any cycle the pipeline does not use the port; buffer empties same edge.
REQ-017 SHALL implement states IDLE (buffer empty), WAIT (buffer full, blocked), STALL (pipe_stall=1): IDLE->WAIT on accept while blocked; WAIT->IDLE on drain; WAIT->STALL when wait counter == STARVE_LIMIT; STALL->IDLE after forced drain.
REQ-018 SHALL count wait cycles in WAIT only, saturating, cleared on drain.
REQ-019 SHALL, when pipe_wr_en=1 (addr!=0) arrives in the cycle after pipe_stall, keep the pipeline winner and remain in STALL (contract violation tolerated, no data loss).
REQ-020 SHALL write both entries in arrival order on same-address collision (pipeline first); WAW hazards are the scoreboard's responsibility.
REQ-021 SHALL drive wr_en=0 when neither source has a valid non-zero write.

Reset
REQ-022 SHALL, with rst_n low: wr_en=0, wr_addr=0, wr_data=0, pipe_stall=0, buffer empty, ext_req_ready=1 after release, state IDLE, counter 0.
REQ-023 SHALL discard a buffered ext entry on reset mid-operation; no write emitted after release.

Configuration
REQ-024 SHALL honour macro RF_WR_STARVE_GUARD_EN: defined -> STALL state, counter and pipe_stall active as REQ-017/018; undefined -> pipe_stall tied 0, no counter, ext waits indefinitely in WAIT.

Structure
REQ-025 SHALL take XLEN=32, REG_ADDR_W=5 and the state enum from shared package rf_pkg.
REQ-026 SHALL place the single-entry ext buffer in sub-module rf_wr_buf (valid/addr/data, load/clear).

Verification
REQ-027 SHALL check: pipe write x5=0xDEADBEEF, no ext -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF next cycle.
REQ-028 SHALL check: pipe idle, ext x7=0x1234 valid -> accepted, wr x7=0x1234 one cycle later, ext_req_ready low for one cycle.
REQ-029 SHALL check: pipe writes every cycle, ext x9 pending, macro defined, STARVE_LIMIT=4 -> pipe_stall high after 4 wait cycles, x9 written the cycle after pipe drops; macro undefined -> x9 never written while pipe busy.
REQ-030 SHALL check: pipe x0 and ext x3 same cycle -> only x3 written; ext x0 accepted -> no write.
REQ-031 SHALL check: rst_n asserted with ext entry buffered -> all outputs 0 immediately, no write after release, ext_req_ready=1.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg -- shared definitions for the register-file write arbiter.
//   XLEN        : datapath width
//   REG_ADDR_W  : register index width
//   rf_arb_st_e : arbiter state (StIdle buffer empty, StWait buffer blocked, StStall pipe stalled)
//   rf_is_wr()  : true for a request that really writes (enabled and not x0)
package rf_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StStall = 2'd2
  } rf_arb_st_e;

  // Writes to x0 are architecturally discarded, so they never count as a request.
  function automatic logic rf_is_wr(input logic en, input logic [REG_ADDR_W-1:0] addr);
    return en && (addr != '0);
  endfunction

endpackage

// File: rtl/rf_wr_buf.sv
// rf_wr_buf -- single-entry holding buffer for a long-latency write.
//   clk_i, rst_ni : clock, asynchronous active-low reset (entry discarded)
//   load_i        : capture addr_i/data_i and mark valid (only issued when empty)
//   clear_i       : drop the entry after it has been written
//   valid_o, addr_o, data_o : buffered entry
module rf_wr_buf
  import rf_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]       data_i,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] addr_o,
  output logic [XLEN-1:0]       data_o
);

  logic                  valid_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]       data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter -- merges the WB-stage write with a buffered long-latency (ext) write onto one
// registered register-file write port. The pipeline always wins; the ext entry drains whenever
// the pipeline leaves the port free.
//   clk_i, rst_ni                       : clock, asynchronous active-low reset
//   pipe_wr_en_i/addr_i/data_i          : WB-stage write (cannot be back-pressured)
//   ext_req_valid_i/ready_o/addr_i/data_i : ext write handshake (ready = buffer empty)
//   pipe_stall_o                        : asks the pipeline to hold pipe_wr_en=0 next cycle
//   wr_en_o/wr_addr_o/wr_data_o         : registered regfile write port (1-cycle latency)
// Build option: define RF_WR_STARVE_GUARD_EN to enable the starvation counter and the STALL
// state; without it pipe_stall_o is tied low and a blocked ext entry waits indefinitely.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  pipe_wr_en_i,
  input  logic [REG_ADDR_W-1:0] pipe_wr_addr_i,
  input  logic [XLEN-1:0]       pipe_wr_data_i,
  input  logic                  ext_req_valid_i,
  output logic                  ext_req_ready_o,
  input  logic [REG_ADDR_W-1:0] ext_req_addr_i,
  input  logic [XLEN-1:0]       ext_req_data_i,
  output logic                  pipe_stall_o,
  output logic                  wr_en_o,
  output logic [REG_ADDR_W-1:0] wr_addr_o,
  output logic [XLEN-1:0]       wr_data_o
);

  if (STARVE_LIMIT == 0) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  logic                  pipe_win, ext_accept, buf_load, drain;
  logic                  buf_valid;
  logic [REG_ADDR_W-1:0] buf_addr;
  logic [XLEN-1:0]       buf_data;

  rf_arb_st_e            state_q;
  logic                  wr_en_q;
  logic [REG_ADDR_W-1:0] wr_addr_q;
  logic [XLEN-1:0]       wr_data_q;

  assign pipe_win        = rf_is_wr(pipe_wr_en_i, pipe_wr_addr_i);
  // Ready comes straight from the buffer flop, so a drained slot reopens only next cycle.
  assign ext_req_ready_o = ~buf_valid;
  assign ext_accept      = ext_req_valid_i && ext_req_ready_o;
  // x0 requests complete the handshake but are never stored.
  assign buf_load        = ext_accept && (ext_req_addr_i != '0);
  assign drain           = buf_valid && !pipe_win;

  rf_wr_buf u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (buf_load),
    .clear_i (drain),
    .addr_i  (ext_req_addr_i),
    .data_i  (ext_req_data_i),
    .valid_o (buf_valid),
    .addr_o  (buf_addr),
    .data_o  (buf_data)
  );

`ifdef RF_WR_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  logic [CntW-1:0] cnt_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef RF_WR_STARVE_GUARD_EN
      cnt_q     <= '0;
`endif
    end else begin
      wr_en_q <= pipe_win || drain;
      if (pipe_win) begin
        wr_addr_q <= pipe_wr_addr_i;
        wr_data_q <= pipe_wr_data_i;
      end else if (drain) begin
        wr_addr_q <= buf_addr;
        wr_data_q <= buf_data;
      end else begin
        wr_addr_q <= '0;
        wr_data_q <= '0;
      end

      unique case (state_q)
        StIdle: begin
          if (buf_load) state_q <= StWait;
        end
        StWait: begin
          if (drain) begin
            state_q <= StIdle;
`ifdef RF_WR_STARVE_GUARD_EN
            cnt_q   <= '0;
          end else if (cnt_q != CntW'(STARVE_LIMIT)) begin
            cnt_q <= cnt_q + CntW'(1);
            // Stall once this blocked cycle brings the count up to the limit.
            if (cnt_q == CntW'(STARVE_LIMIT - 1)) state_q <= StStall;
`endif
          end
        end
        StStall: begin
          // A pipeline write arriving despite the stall still wins; stay until the drain.
          if (drain) begin
            state_q <= StIdle;
`ifdef RF_WR_STARVE_GUARD_EN
            cnt_q   <= '0;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RF_WR_STARVE_GUARD_EN
  assign pipe_stall_o = (state_q == StStall);
`else
  assign pipe_stall_o = 1'b0;
`endif

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter -- directed self-checking bench for rf_wr_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
module tb_rf_wr_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        pipe_wr_en_i;
  logic [4:0]  pipe_wr_addr_i;
  logic [31:0] pipe_wr_data_i;
  logic        ext_req_valid_i;
  logic        ext_req_ready_o;
  logic [4:0]  ext_req_addr_i;
  logic [31:0] ext_req_data_i;
  logic        pipe_stall_o;
  logic        wr_en_o;
  logic [4:0]  wr_addr_o;
  logic [31:0] wr_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wr_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .pipe_wr_en_i    (pipe_wr_en_i),
    .pipe_wr_addr_i  (pipe_wr_addr_i),
    .pipe_wr_data_i  (pipe_wr_data_i),
    .ext_req_valid_i (ext_req_valid_i),
    .ext_req_ready_o (ext_req_ready_o),
    .ext_req_addr_i  (ext_req_addr_i),
    .ext_req_data_i  (ext_req_data_i),
    .pipe_stall_o    (pipe_stall_o),
    .wr_en_o         (wr_en_o),
    .wr_addr_o       (wr_addr_o),
    .wr_data_o       (wr_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pipe(input logic en, input logic [4:0] a, input logic [31:0] d);
    pipe_wr_en_i   = en;
    pipe_wr_addr_i = a;
    pipe_wr_data_i = d;
  endtask

  task automatic ext(input logic v, input logic [4:0] a, input logic [31:0] d);
    ext_req_valid_i = v;
    ext_req_addr_i  = a;
    ext_req_data_i  = d;
  endtask

  task automatic check_port(input string tag, input logic en, input logic [4:0] a,
                            input logic [31:0] d);
    check_eq({tag, "_en"}, {31'd0, wr_en_o}, {31'd0, en});
    check_eq({tag, "_addr"}, {27'd0, wr_addr_o}, {27'd0, a});
    check_eq({tag, "_data"}, wr_data_o, d);
  endtask

  initial begin
    rst_ni = 1'b0;
    pipe(1'b0, 5'd0, 32'd0);
    ext(1'b0, 5'd0, 32'd0);
    repeat (3) tick();

    // Reset state
    check_port("rst", 1'b0, 5'd0, 32'd0);
    check_eq("rst_stall", {31'd0, pipe_stall_o}, 32'd0);
    rst_ni = 1'b1;
    tick();
    check_eq("rst_ready", {31'd0, ext_req_ready_o}, 32'd1);
    check_port("rst_idle", 1'b0, 5'd0, 32'd0);

    // Pipeline write, 1-cycle latency
    pipe(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    pipe(1'b0, 5'd0, 32'd0);
    check_port("pipe_x5", 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check_port("pipe_x5_after", 1'b0, 5'd0, 32'd0);

    // Ext write with idle pipeline: buffered, drained next cycle
    ext(1'b1, 5'd7, 32'h1234);
    tick();
    ext(1'b0, 5'd0, 32'd0);
    check_eq("ext_x7_ready_low", {31'd0, ext_req_ready_o}, 32'd0);
    check_eq("ext_x7_no_wr_yet", {31'd0, wr_en_o}, 32'd0);
    tick();
    check_port("ext_x7", 1'b1, 5'd7, 32'h1234);
    check_eq("ext_x7_ready_back", {31'd0, ext_req_ready_o}, 32'd1);
    tick();
    check_eq("ext_x7_after", {31'd0, wr_en_o}, 32'd0);

    // Pipe x0 with ext x3 in the same cycle: only x3 written
    pipe(1'b1, 5'd0, 32'hBAD0BAD0);
    ext(1'b1, 5'd3, 32'h33);
    tick();
    pipe(1'b0, 5'd0, 32'd0);
    ext(1'b0, 5'd0, 32'd0);
    check_eq("pipe_x0_no_wr", {31'd0, wr_en_o}, 32'd0);
    tick();
    check_port("ext_x3", 1'b1, 5'd3, 32'h33);
    tick();

    // Ext x0: accepted and discarded
    ext(1'b1, 5'd0, 32'h5555);
    tick();
    ext(1'b0, 5'd0, 32'd0);
    check_eq("ext_x0_ready", {31'd0, ext_req_ready_o}, 32'd1);
    check_eq("ext_x0_no_wr1", {31'd0, wr_en_o}, 32'd0);
    tick();
    check_eq("ext_x0_no_wr2", {31'd0, wr_en_o}, 32'd0);

    // Same-address collision: pipeline first, then ext
    pipe(1'b1, 5'd4, 32'hA4);
    ext(1'b1, 5'd4, 32'hE4);
    tick();
    pipe(1'b0, 5'd0, 32'd0);
    ext(1'b0, 5'd0, 32'd0);
    check_port("coll_pipe", 1'b1, 5'd4, 32'hA4);
    tick();
    check_port("coll_ext", 1'b1, 5'd4, 32'hE4);
    tick();

    // Starvation: pipeline writes x1 every cycle, ext x9 pending
    pipe(1'b1, 5'd1, 32'h100);
    ext(1'b1, 5'd9, 32'h99);
    tick();
    ext(1'b0, 5'd0, 32'd0);
    check_port("starve_first", 1'b1, 5'd1, 32'h100);
`ifdef RF_WR_STARVE_GUARD_EN
    for (int k = 1; k <= 4; k++) begin
      pipe(1'b1, 5'd1, 32'h100 + k);
      tick();
      check_port($sformatf("starve_c%0d", k), 1'b1, 5'd1, 32'h100 + k);
      check_eq($sformatf("starve_stall_c%0d", k), {31'd0, pipe_stall_o}, k == 4 ? 32'd1 : 32'd0);
    end
    // Pipeline ignores the stall for one cycle: it still wins, stall holds
    pipe(1'b1, 5'd1, 32'h1AA);
    tick();
    check_port("stall_violate", 1'b1, 5'd1, 32'h1AA);
    check_eq("stall_hold", {31'd0, pipe_stall_o}, 32'd1);
    pipe(1'b0, 5'd0, 32'd0);
    tick();
    check_port("stall_drain_x9", 1'b1, 5'd9, 32'h99);
    check_eq("stall_release", {31'd0, pipe_stall_o}, 32'd0);
    check_eq("stall_ready", {31'd0, ext_req_ready_o}, 32'd1);
`else
    for (int k = 1; k <= 10; k++) begin
      pipe(1'b1, 5'd1, 32'h100 + k);
      tick();
      check_port($sformatf("nostall_c%0d", k), 1'b1, 5'd1, 32'h100 + k);
      check_eq($sformatf("nostall_stall_c%0d", k), {31'd0, pipe_stall_o}, 32'd0);
    end
    check_eq("nostall_ready_low", {31'd0, ext_req_ready_o}, 32'd0);
    pipe(1'b0, 5'd0, 32'd0);
    tick();
    check_port("nostall_drain_x9", 1'b1, 5'd9, 32'h99);
`endif
    tick();
    check_eq("starve_idle", {31'd0, wr_en_o}, 32'd0);

    // Reset with an entry buffered
    pipe(1'b1, 5'd2, 32'h22);
    ext(1'b1, 5'd11, 32'hBB);
    tick();
    ext(1'b0, 5'd0, 32'd0);
    check_eq("rstmid_ready_low", {31'd0, ext_req_ready_o}, 32'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_port("rstmid_async", 1'b0, 5'd0, 32'd0);
    check_eq("rstmid_stall", {31'd0, pipe_stall_o}, 32'd0);
    pipe(1'b0, 5'd0, 32'd0);
    repeat (2) tick();
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("rstmid_no_wr%0d", k), {31'd0, wr_en_o}, 32'd0);
      check_eq($sformatf("rstmid_ready%0d", k), {31'd0, ext_req_ready_o}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
